// File: rtl/tap_rec_pkg.sv
// tap_rec_pkg: tape definitions shared by the recorder and the player
// Contents:
//   ST_*      FSM state encodings
//   CL_*      half-period class codes
//   DEF_*     default pulse thresholds (ticks) and last tape-store address
//   classify  maps a measured half-period to its class
package tap_rec_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PILOT = 3'd1;
    localparam logic [2:0] ST_SYNC  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CLOSE = 3'd4;

    localparam logic [1:0] CL_SHORT = 2'd0;
    localparam logic [1:0] CL_LONG  = 2'd1;
    localparam logic [1:0] CL_PILOT = 2'd2;
    localparam logic [1:0] CL_BAD   = 2'd3;

    localparam int unsigned DEF_T_MIN     = 300;
    localparam int unsigned DEF_T_MID     = 1280;
    localparam int unsigned DEF_T_PILOT   = 1940;
    localparam int unsigned DEF_T_MAX     = 2600;
    localparam int unsigned DEF_PILOT_MIN = 256;
    localparam logic [16:0] DEF_MEM_TOP   = 17'h1FFFF;

    function automatic logic [1:0] classify(input logic [15:0] h, input logic [15:0] t_min,
                                            input logic [15:0] t_mid, input logic [15:0] t_pilot,
                                            input logic [15:0] t_max);
        return (h < t_min) ? CL_BAD : (h < t_mid) ? CL_SHORT : (h < t_pilot) ? CL_LONG :
               (h < t_max) ? CL_PILOT : CL_BAD;
    endfunction

endpackage

// File: rtl/tap_rec_pulse.sv
// tap_rec_pulse: MIC synchroniser, edge detector, half-period timer and classifier
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   tick          T-state enable; the half-period timer counts these
//   mic           raw MIC level
//   flip          one-cycle strobe on each synchronised MIC edge
//   cls           class of the half-period closed by flip (valid with flip)
//   tmo           one-cycle strobe when the timer reaches T_MAX without an edge
module tap_rec_pulse
    import tap_rec_pkg::*;
#(
    parameter int unsigned T_MIN   = DEF_T_MIN,
    parameter int unsigned T_MID   = DEF_T_MID,
    parameter int unsigned T_PILOT = DEF_T_PILOT,
    parameter int unsigned T_MAX   = DEF_T_MAX
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       mic,
    output logic       flip,
    output logic [1:0] cls,
    output logic       tmo
);

    logic [2:0]  sync;
    logic [15:0] h;

    assign flip = sync[2] ^ sync[1];
    assign cls  = classify(h, 16'(T_MIN), 16'(T_MID), 16'(T_PILOT), 16'(T_MAX));
    // an edge in the same tick suppresses the timeout
    assign tmo  = !flip && tick && h == 16'(T_MAX - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= '0;
            h    <= '0;
        end else begin
            sync <= {sync[1:0], mic};
            // the tick coinciding with the edge already belongs to the new half
            h    <= flip ? {15'd0, tick} : (tick && h < 16'(T_MAX)) ? h + 16'd1 : h;
        end
    end

endmodule

// File: rtl/tap_rec.sv
// tap_rec: MIC tape recorder; decodes ROM SAVE pulses and writes .TAP blocks to the tape store
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   tick          T-state enable for all pulse timing
//   arm           recording enable
//   mic           raw MIC level from the port FE latch
//   wr_req        write request, held with wr_addr/wr_data until the wr_ack cycle
//   wr_ack        one-cycle write acknowledge
//   wr_addr       tape-store write address
//   wr_data       tape-store write data
//   busy          FSM not idle
//   blocks        number of closed blocks (wraps)
//   rec_end       next free address
//   err           sticky: pulse mismatch, overrun or store full
module tap_rec
    import tap_rec_pkg::*;
#(
    parameter int unsigned T_MIN     = DEF_T_MIN,
    parameter int unsigned T_MID     = DEF_T_MID,
    parameter int unsigned T_PILOT   = DEF_T_PILOT,
    parameter int unsigned T_MAX     = DEF_T_MAX,
    parameter int unsigned PILOT_MIN = DEF_PILOT_MIN,
    parameter logic [16:0] MEM_TOP   = DEF_MEM_TOP
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        arm,
    input  logic        mic,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic [16:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic [7:0]  blocks,
    output logic [16:0] rec_end,
    output logic        err
);

    // one extra bit so the pointer can sit just past MEM_TOP without wrapping
    localparam logic [17:0] TOP = {1'b0, MEM_TOP};

    logic        flip, tmo, ph, full, wr_is_data;
    logic [1:0]  cls, first_cls, cph;
    logic [2:0]  state, bitcnt;
    logic [15:0] pcnt, nbytes;
    logic [17:0] wr_ptr;
    logic [16:0] blk_start;
    logic [6:0]  shreg;
    logic [7:0]  byte_val;

    assign byte_val = {shreg, cls == CL_LONG};
    assign busy     = state != ST_IDLE;

    tap_rec_pulse #(
        .T_MIN  (T_MIN),
        .T_MID  (T_MID),
        .T_PILOT(T_PILOT),
        .T_MAX  (T_MAX)
    ) pulse (
        .clock(clock),
        .reset(reset),
        .tick (tick),
        .mic  (mic),
        .flip (flip),
        .cls  (cls),
        .tmo  (tmo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pcnt       <= '0;
            ph         <= 1'b0;
            first_cls  <= CL_SHORT;
            shreg      <= '0;
            bitcnt     <= '0;
            wr_ptr     <= '0;
            blk_start  <= '0;
            nbytes     <= '0;
            cph        <= '0;
            full       <= 1'b0;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_is_data <= 1'b0;
            blocks     <= '0;
            rec_end    <= '0;
            err        <= 1'b0;
        end else begin
            if (wr_req && wr_ack) begin
                wr_req <= 1'b0;
                if (wr_is_data) rec_end <= wr_addr + 17'd1;
            end
            case (state)
                ST_IDLE: if (!full && arm && flip && cls == CL_PILOT) begin
                    state <= ST_PILOT;
                    pcnt  <= 16'd1;
                end
                ST_PILOT: if (!arm) state <= ST_IDLE;
                else if (flip) begin
                    if (cls == CL_PILOT) pcnt <= pcnt + {15'd0, pcnt != 16'hFFFF};
                    else state <= (cls == CL_SHORT && pcnt >= 16'(PILOT_MIN)) ? ST_SYNC : ST_IDLE;
                end
                ST_SYNC: if (!arm || (flip && cls != CL_SHORT)) state <= ST_IDLE;
                else if (flip) begin
                    blk_start <= wr_ptr[16:0];
                    nbytes    <= '0;
                    bitcnt    <= '0;
                    ph        <= 1'b0;
                    cph       <= '0;
                    // no room for the length slot: close an empty block and lock up
                    if (wr_ptr + 18'd1 > TOP) begin
                        err   <= 1'b1;
                        full  <= 1'b1;
                        state <= ST_CLOSE;
                    end else begin
                        wr_ptr <= wr_ptr + 18'd2;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: if (flip) begin
                    if ((cls != CL_SHORT && cls != CL_LONG) || (ph && cls != first_cls)) begin
                        err   <= 1'b1;
                        state <= ST_CLOSE;
                    end else if (!ph) begin
                        first_cls <= cls;
                        ph        <= 1'b1;
                    end else begin
                        ph     <= 1'b0;
                        shreg  <= byte_val[6:0];
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            if (wr_ptr > TOP) begin
                                err   <= 1'b1;
                                full  <= 1'b1;
                                state <= ST_CLOSE;
                            end else if (wr_req) err <= 1'b1;
                            else begin
                                wr_req     <= 1'b1;
                                wr_addr    <= wr_ptr[16:0];
                                wr_data    <= byte_val;
                                wr_is_data <= 1'b1;
                                wr_ptr     <= wr_ptr + 18'd1;
                                nbytes     <= nbytes + 16'd1;
                            end
                        end
                    end
                end else if (tmo || !arm) state <= ST_CLOSE;
                // cph walks: length low byte, length high byte, then finish once the store is free
                ST_CLOSE: if (nbytes == 16'd0) begin
                    wr_ptr <= {1'b0, blk_start};
                    state  <= ST_IDLE;
                end else if (!wr_req) begin
                    cph <= cph + 2'd1;
                    if (cph == 2'd2) begin
                        blocks  <= blocks + 8'd1;
                        rec_end <= wr_ptr[16:0];
                        state   <= ST_IDLE;
                    end else begin
                        wr_req     <= 1'b1;
                        wr_addr    <= (cph == 2'd0) ? blk_start : blk_start + 17'd1;
                        wr_data    <= (cph == 2'd0) ? nbytes[7:0] : nbytes[15:8];
                        wr_is_data <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_rec.sv
// tb_tap_rec: self-checking bench for tap_rec with scaled-down pulse thresholds and a small tape store
module tb_tap_rec;

    localparam int TMIN  = 6;
    localparam int TMID  = 20;
    localparam int TPIL  = 30;
    localparam int TMAXV = 40;
    localparam int PMIN  = 16;
    localparam logic [16:0] MTOP = 17'd14;
    localparam int CAP = 13;
    localparam int HP  = 34;
    localparam int HS0 = 11;
    localparam int HS1 = 12;
    localparam int H0  = 13;
    localparam int H1  = 27;

    logic clock = 1'b0, reset = 1'b1, tick = 1'b0, arm = 1'b0, mic = 1'b0, wr_ack = 1'b0;
    logic        wr_req, busy, err;
    logic [16:0] wr_addr, rec_end;
    logic [7:0]  wr_data, blocks;

    tap_rec #(
        .T_MIN(TMIN), .T_MID(TMID), .T_PILOT(TPIL), .T_MAX(TMAXV),
        .PILOT_MIN(PMIN), .MEM_TOP(MTOP)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .arm(arm), .mic(mic),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .blocks(blocks), .rec_end(rec_end), .err(err)
    );

    always #5 clock = ~clock;

    int compared = 0, mismatched = 0;
    int tdiv = 1, tcnt = 0;

    always @(posedge clock) begin
        #1;
        tcnt = tcnt + 1;
        tick = (tcnt % tdiv) == 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // tape store: acks after ack_dly cycles and watches that the request is held
    logic [7:0]  store [0:31];
    int          ack_dly = 1, wait_n = 0, wcnt = 0;
    logic        pend = 1'b0, bad_hold = 1'b0;
    logic [16:0] h_addr;
    logic [7:0]  h_data;

    always @(negedge clock) begin
        if (wr_ack) begin
            wr_ack = 1'b0;
            check("req_low_after_ack", 64'(wr_req), 64'd0);
        end else if (wr_req) begin
            if (!pend) begin
                pend = 1'b1;
                wait_n = 0;
                h_addr = wr_addr;
                h_data = wr_data;
                bad_hold = 1'b0;
            end else if (wr_addr !== h_addr || wr_data !== h_data) bad_hold = 1'b1;
            if (wait_n >= ack_dly) begin
                wr_ack = 1'b1;
                pend = 1'b0;
                if (h_addr < 17'd32) store[h_addr[4:0]] = h_data;
                wcnt++;
                check("hold_stable", 64'(bad_hold), 64'd0);
            end else wait_n++;
        end else begin
            if (pend && !reset) check("req_held", 64'(wr_req), 64'd1);
            pend = 1'b0;
        end
    end

    task automatic half(input int n);
        mic = !mic;
        repeat (n * tdiv) @(posedge clock);
        #1;
    endtask

    task automatic bitpair(input logic b);
        half(b ? H1 : H0);
        half(b ? H1 : H0);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bitpair(v[i]);
    endtask

    task automatic lead(input int pilots);
        repeat (pilots) half(HP);
        half(HS0);
        half(HS1);
    endtask

    // closing edge, silence past the timeout, then a bounded wait for idle
    task automatic settle();
        int k;
        k = 0;
        mic = !mic;
        repeat ((TMAXV + 20) * tdiv) @(posedge clock);
        while ((busy || wr_req) && k < 500) begin
            @(posedge clock);
            k++;
        end
        #1;
        check("settle_idle", {62'd0, busy, wr_req}, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        wcnt = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_store();
        for (int i = 0; i < 32; i++) store[i] = 8'hEE;
    endtask

    typedef struct {
        int          pilots;
        int          n;
        logic [31:0] bytes;
        int          rec;
        int          blks;
        int          wr;
    } vec_t;

    vec_t vecs [4];
    logic [63:0] exp_img;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{pilots: 20, n: 3, bytes: 32'h00FFA500, rec: 5, blks: 1, wr: 5};
        vecs[1] = '{pilots: 20, n: 1, bytes: 32'h42000000, rec: 8, blks: 2, wr: 8};
        vecs[2] = '{pilots: 6,  n: 3, bytes: 32'h123456AA, rec: 8, blks: 2, wr: 8};
        vecs[3] = '{pilots: 20, n: 0, bytes: 32'h00000000, rec: 8, blks: 2, wr: 8};
        clear_store();
        do_reset();
        // reset mid-DATA
        arm = 1'b1;
        lead(20);
        send_byte(8'h5A);
        bitpair(1'b1);
        bitpair(1'b0);
        check("pre_reset_busy", 64'(busy), 64'd1);
        check("pre_reset_rec_end", 64'(rec_end), 64'd3);
        check("pre_reset_wr_data", 64'(wr_data), 64'h5A);
        reset = 1'b1;
        #1;
        check("reset_outputs", {11'd0, wr_req, wr_addr, wr_data, busy, blocks, rec_end, err}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        wcnt = 0;
        clear_store();
        // table: normal blocks, back-to-back, short pilot, empty block
        for (int v = 0; v < 4; v++) begin
            lead(vecs[v].pilots);
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[31 - 8 * i -: 8]);
            settle();
            check($sformatf("vec%0d_rec_end", v), 64'(rec_end), 64'(vecs[v].rec));
            check($sformatf("vec%0d_blocks", v), 64'(blocks), 64'(vecs[v].blks));
            check($sformatf("vec%0d_writes", v), 64'(wcnt), 64'(vecs[v].wr));
            check($sformatf("vec%0d_err", v), 64'(err), 64'd0);
        end
        exp_img = 64'h030000FFA5010042;
        for (int i = 0; i < 8; i++) check($sformatf("store%0d", i), 64'(store[i]), 64'(exp_img[63 - 8 * i -: 8]));
        // byte A5 then a mismatched pair, with a slow store
        ack_dly = 50;
        lead(20);
        send_byte(8'hA5);
        half(H0);
        half(H1);
        settle();
        ack_dly = 1;
        check("bad_pair_store8", 64'(store[8]), 64'h01);
        check("bad_pair_store9", 64'(store[9]), 64'h00);
        check("bad_pair_store10", 64'(store[10]), 64'hA5);
        check("bad_pair_rec_end", 64'(rec_end), 64'd11);
        check("bad_pair_blocks", 64'(blocks), 64'd3);
        check("bad_pair_err", 64'(err), 64'd1);
        // store fills: block at MEM_TOP-3 with 4 bytes
        lead(20);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        settle();
        check("full_store11", 64'(store[11]), 64'h02);
        check("full_store12", 64'(store[12]), 64'h00);
        check("full_store13", 64'(store[13]), 64'h11);
        check("full_store14", 64'(store[14]), 64'h22);
        check("full_rec_end", 64'(rec_end), 64'd15);
        check("full_blocks", 64'(blocks), 64'd4);
        check("full_writes", 64'(wcnt), 64'd15);
        repeat (20) half(HP);
        check("full_locked", 64'(busy), 64'd0);
        half(HS0);
        half(HS1);
        send_byte(8'h77);
        settle();
        check("full_no_writes", 64'(wcnt), 64'd15);
        // arm dropped mid-pilot
        do_reset();
        repeat (10) half(HP);
        check("armed_pilot_busy", 64'(busy), 64'd1);
        arm = 1'b0;
        @(posedge clock);
        #1;
        check("disarm_idle", 64'(busy), 64'd0);
        repeat (15) half(HP);
        half(HS0);
        half(HS1);
        send_byte(8'h99);
        settle();
        check("disarm_writes", 64'(wcnt), 64'd0);
        check("disarm_rec_end", 64'(rec_end), 64'd0);
        // randomized blocks against an arithmetic model of the .TAP layout
        for (int r = 0; r < 6; r++) begin
            int n, k, w, pil;
            logic bad;
            logic [7:0] d [16];
            do_reset();
            tdiv = 1 + r % 2;
            n = (r == 0) ? 15 : int'($urandom_range(0, 15));
            bad = $urandom_range(0, 3) == 0;
            k = bad ? int'($urandom_range(0, n)) : n;
            pil = PMIN + 4 + int'($urandom_range(0, 8));
            for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
            clear_store();
            arm = 1'b1;
            lead(pil);
            for (int i = 0; i < k; i++) send_byte(d[i]);
            if (bad) begin
                half(H0);
                half(H1);
            end
            settle();
            w = (k > CAP) ? CAP : k;
            check($sformatf("rnd%0d_rec_end", r), 64'(rec_end), 64'((w > 0) ? w + 2 : 0));
            check($sformatf("rnd%0d_blocks", r), 64'(blocks), 64'((w > 0) ? 1 : 0));
            check($sformatf("rnd%0d_err", r), 64'(err), 64'(bad || k > CAP));
            check($sformatf("rnd%0d_writes", r), 64'(wcnt), 64'((w > 0) ? w + 2 : 0));
            if (w > 0) begin
                check($sformatf("rnd%0d_len_lo", r), 64'(store[0]), 64'(w));
                check($sformatf("rnd%0d_len_hi", r), 64'(store[1]), 64'd0);
                for (int i = 0; i < w; i++)
                    check($sformatf("rnd%0d_byte%0d", r, i), 64'(store[2 + i]), 64'(d[i]));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
